ldst_queue: RTL and testbench

In-order load/store queue between the issue queue and data memory in the Tomasulo core. Accepts memory ops from `iq` (`resldst_load`) and holds them in program order. Snoops the CDB for pending base and store-data operands. Loads issue to memory when they reach the head and their operands are ready; stores issue only when the ROB commits them. Load results go back to the ROB/CDB as `ld_done`/`ld_tag`/`ld_data`.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/tomasula_types.sv | 28 ++
 rtl/ldst_queue_align.sv | 50 +++++
 rtl/ldst_queue.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ldst_queue.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: RV32I load/store funct3 encodings plus a small helper that
// decides whether an effective address is misaligned for the access width.
package rv32i_types;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes (width field shared with loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Half with bit 0 set, or word with either low bit set, is misaligned.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == F3_SH[1:0]) bad = off[0];
        else if (funct3[1:0] == F3_SW[1:0]) bad = (off != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/tomasula_types.sv
// tomasula_types: shared Tomasulo-core types used by the load/store queue:
// queue depth, ROB tag width, the queue entry record and the head FSM states.
package tomasula_types;

    localparam int LDST_DEPTH = 8;
    localparam int ROB_TAG_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        DRAIN = 2'd2
    } lsq_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_store;
        logic [2:0]           funct3;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [31:0]          base;
        logic                 base_v;
        logic [ROB_TAG_W-1:0] base_tag;
        logic [31:0]          sdata;
        logic                 sdata_v;
        logic [ROB_TAG_W-1:0] sdata_tag;
        logic [31:0]          imm;
    } lsq_entry_t;

endpackage

// File: rtl/ldst_queue_align.sv
// ldst_align: purely combinational byte-lane steering for one memory access.
// Ports:
//   funct3    - RV32I width/sign code of the access
//   addr_lo   - effective address bits [1:0]
//   sdata     - raw store data (rs2)
//   rdata     - raw word returned by data memory
//   mbe       - byte enables, width mask shifted to the byte offset
//   wdata     - store data shifted into its byte lanes
//   load_data - read word shifted down and sign/zero extended
module ldst_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [3:0]  mask;
    logic [31:0] shifted;

    always_comb begin
        mask = 4'b1111;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        // Lanes pushed past byte 3 fall off; only possible when misaligned.
        mbe = mask << addr_lo;
    end

    assign wdata   = sdata << {addr_lo, 3'b000};
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h000000, shifted[7:0]};
            F3_LHU:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/ldst_queue.sv
// ldst_queue: in-order load/store queue between the issue queue and data
// memory. Ops are held in program order in a circular buffer; pending base
// and store-data operands are filled by snooping the CDB. The head op issues
// when its operands are ready (stores also need st_commit from the ROB).
// Optional build macro LDST_MISALIGN_CHK_EN: misaligned head ops are retired
// without a memory access and flagged on ldst_misalign.
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   load_word + op fields         - enqueue strobe and op from the issue queue
//   robs_calculated, cdb_data     - per-tag CDB valid bits and data
//   st_commit                     - ROB lets the head store write
//   flush                         - mispredict: clear the queue
//   data_read/data_write, data_mem_address, data_mbe, data_mem_wdata,
//   data_mem_resp, data_mem_rdata - data memory port
//   ld_done, ld_tag, ld_data      - load result pulse
//   st_done                       - store completion pulse
//   ldst_q_full                   - no free entry
//   dbg_state, dbg_count          - head FSM state and occupancy
//   ldst_misalign                 - (LDST_MISALIGN_CHK_EN only) misalign pulse
//
// Memory handshake: data_read/data_write is a request level that stays high
// until the cycle data_mem_resp is sampled high; the request drops on the
// following edge. Exactly one request is outstanding at a time, and a
// response in the very first cycle of a request is accepted.
module ldst_queue
    import tomasula_types::*;
    import rv32i_types::*;
#(
    parameter int DEPTH = LDST_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load_word,
    input  logic                        is_store,
    input  logic [2:0]                  funct3,
    input  logic [TAG_W-1:0]            rob_tag,
    input  logic [31:0]                 base_data,
    input  logic                        base_valid,
    input  logic [TAG_W-1:0]            base_tag,
    input  logic [31:0]                 sdata,
    input  logic                        sdata_valid,
    input  logic [TAG_W-1:0]            sdata_tag,
    input  logic [31:0]                 imm,
    input  logic [(2**TAG_W)-1:0]       robs_calculated,
    input  logic [(2**TAG_W)-1:0][31:0] cdb_data,
    input  logic                        st_commit,
    input  logic                        flush,
    input  logic                        data_mem_resp,
    input  logic [31:0]                 data_mem_rdata,
    output logic                        ldst_q_full,
    output logic                        data_read,
    output logic                        data_write,
    output logic [31:0]                 data_mem_address,
    output logic [3:0]                  data_mbe,
    output logic [31:0]                 data_mem_wdata,
    output logic                        ld_done,
    output logic [TAG_W-1:0]            ld_tag,
    output logic [31:0]                 ld_data,
    output logic                        st_done,
    output lsq_state_t                  dbg_state,
    output logic [$clog2(DEPTH):0]      dbg_count
`ifdef LDST_MISALIGN_CHK_EN
    ,
    output logic                        ldst_misalign
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    lsq_entry_t       q [DEPTH];
    lsq_entry_t       hd;
    lsq_entry_t       enq_entry;
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    lsq_state_t       state_q, state_n;

    logic        enq, deq, issue, report, hd_ready;
    logic [31:0] eff;

    // Snapshot of the op in flight, used when its response comes back.
    logic             cur_is_store;
    logic [2:0]       cur_funct3;
    logic [1:0]       cur_off;
    logic [TAG_W-1:0] cur_tag;

    logic [2:0]  a_funct3;
    logic [1:0]  a_off;
    logic [3:0]  a_mbe;
    logic [31:0] a_wdata, a_ldata;

`ifdef LDST_MISALIGN_CHK_EN
    logic misal_hit;
`endif

    assign ldst_q_full = (count == (PTR_W+1)'(DEPTH));
    assign enq         = load_word && !ldst_q_full && !flush;
    assign hd          = q[head];
    assign eff         = hd.base + hd.imm;
    assign hd_ready    = hd.valid && hd.base_v && (!hd.is_store || (hd.sdata_v && st_commit));
    assign dbg_state   = state_q;
    assign dbg_count   = count;

    // New entry, with a same-cycle CDB broadcast bypassed into a pending operand.
    always_comb begin
        enq_entry           = '0;
        enq_entry.valid     = 1'b1;
        enq_entry.is_store  = is_store;
        enq_entry.funct3    = funct3;
        enq_entry.rob_tag   = rob_tag;
        enq_entry.imm       = imm;
        enq_entry.base      = base_data;
        enq_entry.base_v    = base_valid;
        enq_entry.base_tag  = base_tag;
        enq_entry.sdata     = sdata;
        enq_entry.sdata_tag = sdata_tag;
        // Loads never wait on rs2.
        enq_entry.sdata_v   = sdata_valid || !is_store;
        if (!base_valid && robs_calculated[base_tag]) begin
            enq_entry.base   = cdb_data[base_tag];
            enq_entry.base_v = 1'b1;
        end
        if (is_store && !sdata_valid && robs_calculated[sdata_tag]) begin
            enq_entry.sdata   = cdb_data[sdata_tag];
            enq_entry.sdata_v = 1'b1;
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid && !q[i].base_v && robs_calculated[q[i].base_tag]) begin
                    q[i].base   <= cdb_data[q[i].base_tag];
                    q[i].base_v <= 1'b1;
                end
                if (q[i].valid && !q[i].sdata_v && robs_calculated[q[i].sdata_tag]) begin
                    q[i].sdata   <= cdb_data[q[i].sdata_tag];
                    q[i].sdata_v <= 1'b1;
                end
            end
            if (deq) begin
                q[head].valid <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            // The tail slot is free whenever enq is allowed, so it never
            // collides with the head being retired.
            if (enq) begin
                q[tail] <= enq_entry;
                tail    <= tail + PTR_W'(1);
            end
            if (enq && !deq) count <= count + (PTR_W+1)'(1);
            else if (!enq && deq) count <= count - (PTR_W+1)'(1);
        end
    end

    // Head FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_n;
    end

    // Head FSM next state and control strobes.
    always_comb begin
        state_n = state_q;
        issue   = 1'b0;
        deq     = 1'b0;
        report  = 1'b0;
`ifdef LDST_MISALIGN_CHK_EN
        misal_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!flush && hd_ready) begin
`ifdef LDST_MISALIGN_CHK_EN
                    if (misaligned(hd.funct3, eff[1:0])) begin
                        misal_hit = 1'b1;
                        deq       = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_n = MEM;
                    end
`else
                    issue   = 1'b1;
                    state_n = MEM;
`endif
                end
            end
            MEM: begin
                if (data_mem_resp) begin
                    state_n = IDLE;
                    // A flush landing with the response discards the result.
                    if (!flush) begin
                        deq    = 1'b1;
                        report = 1'b1;
                    end
                end else if (flush) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (data_mem_resp) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane steering: the head op while idle, the in-flight op otherwise.
    assign a_funct3 = (state_q == IDLE) ? hd.funct3 : cur_funct3;
    assign a_off    = (state_q == IDLE) ? eff[1:0]  : cur_off;

    ldst_align u_align (
        .funct3    (a_funct3),
        .addr_lo   (a_off),
        .sdata     (hd.sdata),
        .rdata     (data_mem_rdata),
        .mbe       (a_mbe),
        .wdata     (a_wdata),
        .load_data (a_ldata)
    );

    // Registered memory request and result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_read        <= 1'b0;
            data_write       <= 1'b0;
            data_mem_address <= '0;
            data_mbe         <= '0;
            data_mem_wdata   <= '0;
            ld_done          <= 1'b0;
            ld_tag           <= '0;
            ld_data          <= '0;
            st_done          <= 1'b0;
            cur_is_store     <= 1'b0;
            cur_funct3       <= '0;
            cur_off          <= '0;
            cur_tag          <= '0;
`ifdef LDST_MISALIGN_CHK_EN
            ldst_misalign    <= 1'b0;
`endif
        end else begin
            ld_done <= 1'b0;
            ld_tag  <= '0;
            ld_data <= '0;
            st_done <= 1'b0;
`ifdef LDST_MISALIGN_CHK_EN
            ldst_misalign <= 1'b0;
`endif
            if (issue) begin
                data_read        <= !hd.is_store;
                data_write       <= hd.is_store;
                data_mem_address <= {eff[31:2], 2'b00};
                data_mbe         <= a_mbe;
                data_mem_wdata   <= a_wdata;
                cur_is_store     <= hd.is_store;
                cur_funct3       <= hd.funct3;
                cur_off          <= eff[1:0];
                cur_tag          <= hd.rob_tag;
            end else if (data_mem_resp && (state_q != IDLE)) begin
                data_read  <= 1'b0;
                data_write <= 1'b0;
            end
            if (report) begin
                ld_done <= !cur_is_store;
                st_done <= cur_is_store;
                if (!cur_is_store) begin
                    ld_tag  <= cur_tag;
                    ld_data <= a_ldata;
                end
            end
`ifdef LDST_MISALIGN_CHK_EN
            if (misal_hit) begin
                ld_done       <= !hd.is_store;
                st_done       <= hd.is_store;
                ldst_misalign <= 1'b1;
                if (!hd.is_store) ld_tag <= hd.rob_tag;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ldst_queue.sv
// tb_ldst_queue: self-checking bench for ldst_queue. A queue of op records
// models program order; expected addresses, byte enables, store data and
// load results are computed arithmetically from each op.
module tb_ldst_queue;
    import tomasula_types::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              load_word = 0, is_store = 0;
    logic [2:0]        funct3 = 0, rob_tag = 0, base_tag = 0, sdata_tag = 0;
    logic [31:0]       base_data = 0, sdata = 0, imm = 0;
    logic              base_valid = 0, sdata_valid = 0;
    logic [7:0]        robs_calculated = 0;
    logic [7:0][31:0]  cdb_data = '0;
    logic              st_commit = 0, flush = 0, data_mem_resp = 0;
    logic [31:0]       data_mem_rdata = 0;
    logic              ldst_q_full, data_read, data_write, ld_done, st_done;
    logic [31:0]       data_mem_address, data_mem_wdata, ld_data;
    logic [3:0]        data_mbe;
    logic [2:0]        ld_tag;
    lsq_state_t        dbg_state;
    logic [3:0]        dbg_count;
`ifdef LDST_MISALIGN_CHK_EN
    logic              ldst_misalign;
`endif

    ldst_queue dut (
        .clk(clk), .reset_n(reset_n), .load_word(load_word), .is_store(is_store),
        .funct3(funct3), .rob_tag(rob_tag), .base_data(base_data), .base_valid(base_valid),
        .base_tag(base_tag), .sdata(sdata), .sdata_valid(sdata_valid), .sdata_tag(sdata_tag),
        .imm(imm), .robs_calculated(robs_calculated), .cdb_data(cdb_data),
        .st_commit(st_commit), .flush(flush), .data_mem_resp(data_mem_resp),
        .data_mem_rdata(data_mem_rdata), .ldst_q_full(ldst_q_full), .data_read(data_read),
        .data_write(data_write), .data_mem_address(data_mem_address), .data_mbe(data_mbe),
        .data_mem_wdata(data_mem_wdata), .ld_done(ld_done), .ld_tag(ld_tag), .ld_data(ld_data),
        .st_done(st_done), .dbg_state(dbg_state), .dbg_count(dbg_count)
`ifdef LDST_MISALIGN_CHK_EN
        , .ldst_misalign(ldst_misalign)
`endif
    );

    // ---------------- model / scoreboard ----------------
    typedef struct packed {
        bit        is_store;
        bit [2:0]  f3;
        bit [2:0]  tag;
        bit [31:0] base;
        bit        bv;
        bit [2:0]  btag;
        bit [31:0] sdata;
        bit        sv;
        bit [2:0]  stag;
        bit [31:0] imm;
    } op_t;

    op_t         model_q[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned op_bytes(input bit [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit [31:0] ea_of(input op_t o);
        return o.base + o.imm;
    endfunction

    function automatic bit [3:0] exp_mbe(input op_t o);
        int unsigned off = ea_of(o) % 4;
        int unsigned m = ((1 << op_bytes(o.f3)) - 1) << off;
        return 4'(m % 16);
    endfunction

    function automatic bit [31:0] exp_wdata(input op_t o);
        int unsigned off = ea_of(o) % 4;
        bit [63:0] t = {32'h0, o.sdata} << (8 * off);
        return t[31:0];
    endfunction

    function automatic bit [31:0] exp_load(input op_t o, input bit [31:0] rdata);
        int unsigned off = ea_of(o) % 4;
        int unsigned n = op_bytes(o.f3);
        longint unsigned v = longint'(rdata) >> (8 * off);
        longint unsigned m = 64'd1 << (8 * n);
        bit [63:0] r;
        v = v % m;
        if (!o.f3[2] && n < 4 && v >= m / 2) v = v + (64'h1_0000_0000 - m);
        r = v;
        return r[31:0];
    endfunction

    function automatic op_t rand_op(input bit store);
        op_t o;
        o.is_store = store;
        if (store) o.f3 = 3'($urandom_range(0, 2));
        else begin
            case ($urandom_range(0, 4))
                0: o.f3 = 3'b000;
                1: o.f3 = 3'b001;
                2: o.f3 = 3'b010;
                3: o.f3 = 3'b100;
                default: o.f3 = 3'b101;
            endcase
        end
        o.tag   = 3'($urandom);
        o.base  = $urandom;
        o.bv    = 1'b1;
        o.btag  = 3'($urandom);
        o.sdata = $urandom;
        o.sv    = 1'b1;
        o.stag  = 3'($urandom);
        o.imm   = 32'($urandom_range(0, 511)) - 32'd256;
        return o;
    endfunction

    function automatic op_t mk_op(input bit st, input bit [2:0] f3, input bit [2:0] tag,
                                  input bit [31:0] base, input bit bv, input bit [2:0] btag,
                                  input bit [31:0] sd, input bit [31:0] im);
        op_t o;
        o = '0;
        o.is_store = st; o.f3 = f3; o.tag = tag; o.base = base; o.bv = bv;
        o.btag = btag; o.sdata = sd; o.sv = 1'b1; o.imm = im;
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_op(input op_t o);
        load_word   = 1'b1;
        is_store    = o.is_store;
        funct3      = o.f3;
        rob_tag     = o.tag;
        base_data   = o.base;
        base_valid  = o.bv;
        base_tag    = o.btag;
        sdata       = o.sdata;
        sdata_valid = o.sv;
        sdata_tag   = o.stag;
        imm         = o.imm;
    endtask

    // Model side of an enqueue; mirrors the rule that a full queue ignores it.
    task automatic model_push(input op_t o);
        if (model_q.size() < 8) begin
            if (!o.bv && robs_calculated[o.btag]) begin
                o.base = cdb_data[o.btag];
                o.bv   = 1'b1;
            end
            model_q.push_back(o);
        end
    endtask

    task automatic enqueue(input op_t o);
        drive_op(o);
        model_push(o);
        tick();
        load_word = 1'b0;
    endtask

    task automatic broadcast(input bit [2:0] tag, input bit [31:0] val);
        robs_calculated[tag] = 1'b1;
        cdb_data[tag] = val;
        foreach (model_q[i]) begin
            if (!model_q[i].bv && model_q[i].btag == tag) begin
                model_q[i].base = val;
                model_q[i].bv   = 1'b1;
            end
        end
        tick();
        robs_calculated = '0;
    endtask

    task automatic wait_req(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (data_read || data_write) got = 1'b1;
            else tick();
        end
    endtask

    // Wait for the model's head op on the memory port, check the request,
    // respond, and check the completion pulse. Optionally enqueue in the
    // response cycle.
    task automatic process_head(input bit [31:0] rdata, input bit enq_same, input op_t nop);
        op_t h;
        bit  got;
        int  d;
        h = model_q[0];
        exp_q.push_back(ea_of(h) & 32'hFFFF_FFFC);
        exp_q.push_back({28'h0, exp_mbe(h)});
        exp_q.push_back(exp_wdata(h));
        wait_req(30, got);
        chk("req_seen", {31'h0, got}, 32'h1);
        if (got) begin
            chk("req_read", {31'h0, data_read}, {31'h0, !h.is_store});
            chk("req_write", {31'h0, data_write}, {31'h0, h.is_store});
            chk("addr", data_mem_address, exp_q.pop_front());
            chk("mbe", {28'h0, data_mbe}, exp_q.pop_front());
            if (h.is_store) chk("wdata", data_mem_wdata, exp_q.pop_front());
            else void'(exp_q.pop_front());
            d = $urandom_range(0, 2);
            repeat (d) begin
                tick();
                chk("req_held", {31'h0, data_read | data_write}, 32'h1);
            end
            data_mem_resp  = 1'b1;
            data_mem_rdata = rdata;
            if (enq_same) begin
                drive_op(nop);
                model_push(nop);
            end
            tick();
            data_mem_resp = 1'b0;
            load_word     = 1'b0;
            chk("ld_done", {31'h0, ld_done}, {31'h0, !h.is_store});
            chk("st_done", {31'h0, st_done}, {31'h0, h.is_store});
            if (!h.is_store) begin
                chk("ld_tag", {29'h0, ld_tag}, {29'h0, h.tag});
                chk("ld_data", ld_data, exp_load(h, rdata));
            end
        end else begin
            repeat (3) void'(exp_q.pop_front());
        end
        void'(model_q.pop_front());
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        op_t o;
        bit  got;

        // Reset state
        #12;
        chk("rst_full", {31'h0, ldst_q_full}, 32'h0);
        chk("rst_read", {31'h0, data_read}, 32'h0);
        chk("rst_write", {31'h0, data_write}, 32'h0);
        chk("rst_ld_done", {31'h0, ld_done}, 32'h0);
        chk("rst_st_done", {31'h0, st_done}, 32'h0);
        chk("rst_count", {28'h0, dbg_count}, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        reset_n = 1'b1;
        tick();

        // Load word with exact latency
        enqueue(mk_op(1'b0, 3'b010, 3'd2, 32'h1000, 1'b1, 3'd0, 32'h0, 32'd4));
        chk("lw_lat_c1", {31'h0, data_read}, 32'h0);
        tick();
        chk("lw_lat_c2", {31'h0, data_read}, 32'h1);
        chk("lw_addr_const", data_mem_address, 32'h1004);
        process_head(32'h600d600d, 1'b0, '0);
        chk("lw_ld_data_const", ld_data, 32'h600d600d);
        tick();
        chk("lw_pulse_end", {31'h0, ld_done}, 32'h0);
        chk("lw_count", {28'h0, dbg_count}, 32'h0);

        // LB / LBU at byte 3
        enqueue(mk_op(1'b0, 3'b000, 3'd3, 32'h1000, 1'b1, 3'd0, 32'h0, 32'd3));
        process_head(32'h8000_0000, 1'b0, '0);
        chk("lb_const", ld_data, 32'hFFFF_FF80);
        enqueue(mk_op(1'b0, 3'b100, 3'd4, 32'h1000, 1'b1, 3'd0, 32'h0, 32'd3));
        process_head(32'h8000_0000, 1'b0, '0);
        chk("lbu_const", ld_data, 32'h0000_0080);

        // Store waits for commit
        st_commit = 1'b0;
        enqueue(mk_op(1'b1, 3'b001, 3'd1, 32'h2000, 1'b1, 3'd0, 32'h1234_abcd, 32'd2));
        repeat (5) begin
            chk("st_no_commit", {31'h0, data_write}, 32'h0);
            tick();
        end
        st_commit = 1'b1;
        process_head(32'h0, 1'b0, '0);
        st_commit = 1'b0;

        // CDB wakeup, then same-cycle bypass
        enqueue(mk_op(1'b0, 3'b010, 3'd6, 32'h0, 1'b0, 3'd5, 32'h0, 32'd0));
        repeat (2) begin
            chk("wake_wait", {31'h0, data_read}, 32'h0);
            tick();
        end
        broadcast(3'd5, 32'h3000);
        chk("wake_c1", {31'h0, data_read}, 32'h0);
        tick();
        chk("wake_c2", {31'h0, data_read}, 32'h1);
        process_head($urandom, 1'b0, '0);
        robs_calculated[5] = 1'b1;
        cdb_data[5] = 32'h3000;
        enqueue(mk_op(1'b0, 3'b010, 3'd7, 32'h0, 1'b0, 3'd5, 32'h0, 32'd0));
        robs_calculated = '0;
        chk("byp_c1", {31'h0, data_read}, 32'h0);
        tick();
        chk("byp_c2", {31'h0, data_read}, 32'h1);
        process_head($urandom, 1'b0, '0);

        // Random mixed traffic
        st_commit = 1'b1;
        repeat (20) begin
            enqueue(rand_op(1'($urandom_range(0, 1))));
            process_head($urandom, 1'b0, '0);
        end

        // Full, ignored 9th enqueue, then dequeue+enqueue across the wrap
        for (int i = 0; i < 8; i++) begin
            o = rand_op(1'b0);
            o.bv = 1'b0;
            o.btag = 3'd7;
            enqueue(o);
        end
        chk("full_flag", {31'h0, ldst_q_full}, 32'h1);
        chk("full_count", {28'h0, dbg_count}, 32'h8);
        enqueue(rand_op(1'b0));
        chk("ninth_ignored", {28'h0, dbg_count}, 32'h8);
        broadcast(3'd7, $urandom);
        process_head($urandom, 1'b1, rand_op(1'b0));
        chk("full_deq_enq", {28'h0, dbg_count}, 32'h7);
        repeat (10) begin
            process_head($urandom, 1'b1, rand_op(1'($urandom_range(0, 1))));
            chk("wrap_count", {28'h0, dbg_count}, 32'h7);
        end
        repeat (7) process_head($urandom, 1'b0, '0);
        tick();
        chk("drained", {28'h0, dbg_count}, 32'h0);
        st_commit = 1'b0;

        // Flush while a load is in MEM
        enqueue(mk_op(1'b0, 3'b010, 3'd1, 32'h4000, 1'b1, 3'd0, 32'h0, 32'd0));
        enqueue(mk_op(1'b0, 3'b010, 3'd2, 32'h4100, 1'b1, 3'd0, 32'h0, 32'd0));
        chk("fl_in_mem", {31'h0, data_read}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_held", {31'h0, data_read}, 32'h1);
        chk("fl_count", {28'h0, dbg_count}, 32'h0);
        chk("fl_state", 32'(dbg_state), 32'(DRAIN));
        tick();
        chk("fl_held2", {31'h0, data_read}, 32'h1);
        data_mem_resp = 1'b1;
        tick();
        data_mem_resp = 1'b0;
        chk("fl_no_ld_done", {31'h0, ld_done}, 32'h0);
        chk("fl_read_drop", {31'h0, data_read}, 32'h0);
        chk("fl_idle", 32'(dbg_state), 32'(IDLE));
        model_q.delete();
        enqueue(mk_op(1'b0, 3'b101, 3'd3, 32'h5000, 1'b1, 3'd0, 32'h0, 32'd2));
        process_head(32'hbeef_1234, 1'b0, '0);

        // Flush while a committed store is in MEM: completes silently
        st_commit = 1'b1;
        enqueue(mk_op(1'b1, 3'b010, 3'd4, 32'h6000, 1'b1, 3'd0, 32'hcafe_f00d, 32'd8));
        wait_req(20, got);
        chk("fs_req", {31'h0, got & data_write}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        st_commit = 1'b0;
        chk("fs_held", {31'h0, data_write}, 32'h1);
        data_mem_resp = 1'b1;
        tick();
        data_mem_resp = 1'b0;
        chk("fs_no_st_done", {31'h0, st_done}, 32'h0);
        chk("fs_write_drop", {31'h0, data_write}, 32'h0);
        model_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
